// File: rtl/axil_mem_master.sv
// Bridges a single-request load/store port onto an AXI4-Lite master.
// One transaction in flight; every AXI and response output is driven from a register.
module axil_mem_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0] wstrb_reg;
    logic                  awvalid_reg;
    logic                  wvalid_reg;
    logic                  arvalid_reg;
    logic                  bready_reg;
    logic                  rready_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_err_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;

    // A channel counts as done once its valid has dropped or it handshakes this cycle.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_reg || m_axil_awready;
    assign w_done  = !wvalid_reg  || m_axil_wready;

    // Only the error bit of the response codes matters here.
    logic unused_resp_bits;
    assign unused_resp_bits = m_axil_bresp[0] ^ m_axil_rresp[0];

    assign req_ready = (state_reg == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            bready_reg    <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        wstrb_reg <= req_wstrb;
                        if (req_we) begin
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= WR_ADDR_DATA;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (awvalid_reg && m_axil_awready) awvalid_reg <= 1'b0;
                    if (wvalid_reg && m_axil_wready)   wvalid_reg  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_reg <= 1'b1;
                        state_reg  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axil_bvalid) begin
                        bready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= m_axil_bresp[1];
                        rsp_rdata_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (m_axil_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axil_rvalid) begin
                        rready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= m_axil_rresp[1];
                        rsp_rdata_reg <= m_axil_rdata;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_axil_awaddr  = addr_reg;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_reg;
    assign m_axil_wdata   = wdata_reg;
    assign m_axil_wstrb   = wstrb_reg;
    assign m_axil_wvalid  = wvalid_reg;
    assign m_axil_bready  = bready_reg;
    assign m_axil_araddr  = addr_reg;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_reg;
    assign m_axil_rready  = rready_reg;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_axil_mem_master.sv
// Directed bench for axil_mem_master against a small AXI4-Lite RAM model whose
// readies rise one cycle after valid (plus an optional stall per channel).
module tb_axil_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [15:0] m_axil_awaddr;
    logic [2:0]  m_axil_awprot;
    logic        m_axil_awvalid;
    logic        m_axil_awready;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_wready;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_bvalid;
    logic        m_axil_bready;
    logic [15:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid;
    logic        m_axil_rready;

    int total = 0;
    int bad = 0;

    axil_mem_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    logic [31:0] mem [16];
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic        r_force = 1'b0;
    logic [31:0] r_force_data = '0;
    int          aw_cnt, w_cnt, ar_cnt;
    int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;
    logic        aw_got, w_got;
    logic [15:0] aw_addr_l, last_awaddr;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;

    logic        aw_now, w_now, ar_now, wr_fire;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    assign aw_now  = m_axil_awvalid && m_axil_awready;
    assign w_now   = m_axil_wvalid && m_axil_wready;
    assign ar_now  = m_axil_arvalid && m_axil_arready;
    assign wr_fire = (aw_got || aw_now) && (w_got || w_now);
    assign wr_addr = aw_now ? m_axil_awaddr : aw_addr_l;
    assign wr_data = w_now ? m_axil_wdata : w_data_l;
    assign wr_strb = w_now ? m_axil_wstrb : w_strb_l;

    always @(posedge clk) begin
        if (rst) begin
            m_axil_awready <= 1'b0;
            m_axil_wready  <= 1'b0;
            m_axil_arready <= 1'b0;
            m_axil_bvalid  <= 1'b0;
            m_axil_rvalid  <= 1'b0;
            m_axil_bresp   <= 2'b00;
            m_axil_rresp   <= 2'b00;
            m_axil_rdata   <= '0;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            for (int i = 0; i < 8; i++) mem[8+i] <= 32'hA000_0000 + i;
        end else begin
            m_axil_awready <= m_axil_awvalid && !m_axil_awready && !aw_got && (aw_cnt >= aw_delay);
            m_axil_wready  <= m_axil_wvalid && !m_axil_wready && !w_got && (w_cnt >= w_delay);
            m_axil_arready <= m_axil_arvalid && !m_axil_arready && !m_axil_rvalid && (ar_cnt >= ar_delay);
            aw_cnt <= (m_axil_awvalid && !m_axil_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axil_wvalid && !m_axil_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (m_axil_arvalid && !m_axil_arready) ? ar_cnt + 1 : 0;
            if (aw_now) begin aw_hs_n <= aw_hs_n + 1; last_awaddr <= m_axil_awaddr; aw_addr_l <= m_axil_awaddr; end
            if (w_now) begin w_hs_n <= w_hs_n + 1; w_data_l <= m_axil_wdata; w_strb_l <= m_axil_wstrb; end
            if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
            if (wr_fire) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
                m_axil_bvalid <= 1'b1;
                m_axil_bresp  <= b_resp_cfg;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_now) aw_got <= 1'b1;
                if (w_now)  w_got  <= 1'b1;
            end
            if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
            if (ar_now) begin
                ar_hs_n       <= ar_hs_n + 1;
                m_axil_rvalid <= 1'b1;
                m_axil_rdata  <= r_force ? r_force_data : mem[m_axil_araddr[5:2]];
                m_axil_rresp  <= r_resp_cfg;
            end
        end
    end

    // ---------------- monitors ----------------
    int          viol = 0;
    logic        aw_stall_prev = 1'b0, w_stall_prev = 1'b0, ar_stall_prev = 1'b0;
    logic [15:0] awaddr_prev, araddr_prev;
    logic [35:0] wpay_prev;
    int          rsp_cyc_log [64];
    logic [31:0] rsp_dat_log [64];
    int          rsp_log_n = 0;

    always @(negedge clk) begin
        if (rst) begin
            aw_stall_prev <= 1'b0; w_stall_prev <= 1'b0; ar_stall_prev <= 1'b0;
        end else begin
            viol <= viol
                + int'(aw_stall_prev && m_axil_awaddr !== awaddr_prev)
                + int'(w_stall_prev && {m_axil_wstrb, m_axil_wdata} !== wpay_prev)
                + int'(ar_stall_prev && m_axil_araddr !== araddr_prev)
                + int'(aw_stall_prev && !m_axil_awvalid)
                + int'(w_stall_prev && !m_axil_wvalid)
                + int'(ar_stall_prev && !m_axil_arvalid);
            aw_stall_prev <= m_axil_awvalid && !m_axil_awready;
            w_stall_prev  <= m_axil_wvalid && !m_axil_wready;
            ar_stall_prev <= m_axil_arvalid && !m_axil_arready;
            awaddr_prev   <= m_axil_awaddr;
            araddr_prev   <= m_axil_araddr;
            wpay_prev     <= {m_axil_wstrb, m_axil_wdata};
        end
        if (rsp_valid && rsp_log_n < 64) begin
            rsp_cyc_log[rsp_log_n] <= cyc;
            rsp_dat_log[rsp_log_n] <= rsp_rdata;
            rsp_log_n <= rsp_log_n + 1;
        end
    end

    // ---------------- request driver ----------------
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd, output logic er,
                          output int lat, output logic rsp_after, output logic to);
        int n;
        int acc_c;
        to = 1'b0;
        req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!req_ready) to = 1'b1;
        @(posedge clk); #1;
        acc_c = cyc;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) to = 1'b1;
        lat = cyc - acc_c;
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
        rsp_after = rsp_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({req_ready, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready,
             m_axil_rready, rsp_valid, rsp_err} !== 8'h00 || rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b awv=%b wv=%b arv=%b br=%b rr=%b rv=%b err=%b rdata=%h, want all 0",
                     req_ready, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready,
                     m_axil_rready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er, ra, to; int lat; int aw0, w0;
        aw0 = aw_hs_n; w0 = w_hs_n;
        do_req(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat, ra, to);
        $display("store 0x0010 <= deadbeef: err=%b lat=%0d", er, lat);
        total++; if (to) begin bad++; $display("FAIL store_timeout: got timeout want response"); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL store_err: got %b want 0", er); end
        total++; if (lat !== 3) begin bad++; $display("FAIL store_latency: got %0d want 3 edges", lat); end
        total++; if (aw_hs_n - aw0 !== 1 || w_hs_n - w0 !== 1) begin
            bad++; $display("FAIL store_handshakes: got aw=%0d w=%0d want 1/1", aw_hs_n - aw0, w_hs_n - w0); end
        total++; if (last_awaddr !== 16'h0010) begin bad++; $display("FAIL store_awaddr: got %h want 0010", last_awaddr); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL store_rsp_pulse: got rsp_valid=%b next cycle want 0", ra); end
        do_req(1'b0, 16'h0010, 32'h0, 4'h0, rd, er, lat, ra, to);
        $display("load 0x0010: rdata=%h err=%b lat=%0d", rd, er, lat);
        total++; if (to || rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_data: got %h want deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL load_err: got %b want 0", er); end
        total++; if (lat !== 3) begin bad++; $display("FAIL load_latency: got %0d want 3 edges", lat); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL load_rsp_pulse: got rsp_valid=%b next cycle want 0", ra); end
    endtask

    task automatic test_partial_store;
        logic [31:0] rd; logic er, ra, to; int lat;
        do_req(1'b1, 16'h0014, 32'h1122_3344, 4'hF, rd, er, lat, ra, to);
        do_req(1'b1, 16'h0014, 32'h0000_00AA, 4'h1, rd, er, lat, ra, to);
        do_req(1'b0, 16'h0014, 32'h0, 4'h0, rd, er, lat, ra, to);
        $display("partial store 0x0014: rdata=%h", rd);
        total++; if (to || rd !== 32'h1122_33AA) begin bad++; $display("FAIL partial_store: got %h want 112233aa", rd); end
    endtask

    task automatic test_stalls;
        logic [31:0] rd; logic er, ra, to; int lat; int aw0, w0, r0, v0;
        for (int k = 0; k < 2; k++) begin
            aw_delay = (k == 0) ? 4 : 0;
            w_delay  = (k == 0) ? 0 : 4;
            aw0 = aw_hs_n; w0 = w_hs_n; r0 = rsp_log_n; v0 = viol;
            do_req(1'b1, 16'h0018, 32'h5566_7788 + k, 4'hF, rd, er, lat, ra, to);
            repeat (3) @(posedge clk);
            #1;
            $display("stall %s: aw=%0d w=%0d rsp=%0d lat=%0d", (k == 0) ? "aw" : "w",
                     aw_hs_n - aw0, w_hs_n - w0, rsp_log_n - r0, lat);
            total++; if (to || aw_hs_n - aw0 !== 1 || w_hs_n - w0 !== 1) begin
                bad++; $display("FAIL stall%0d_handshakes: got aw=%0d w=%0d want 1/1", k, aw_hs_n - aw0, w_hs_n - w0); end
            total++; if (viol - v0 !== 0) begin bad++; $display("FAIL stall%0d_stable: got %0d changes want 0", k, viol - v0); end
            total++; if (rsp_log_n - r0 !== 1 || er !== 1'b0) begin
                bad++; $display("FAIL stall%0d_response: got %0d rsp err=%b want 1 rsp err=0", k, rsp_log_n - r0, er); end
            aw_delay = 0; w_delay = 0;
            do_req(1'b0, 16'h0018, 32'h0, 4'h0, rd, er, lat, ra, to);
            total++; if (rd !== 32'h5566_7788 + k) begin
                bad++; $display("FAIL stall%0d_readback: got %h want %h", k, rd, 32'h5566_7788 + k); end
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er, ra, to; int lat;
        b_resp_cfg = 2'b10;
        do_req(1'b1, 16'h0008, 32'h0BAD_0BAD, 4'hF, rd, er, lat, ra, to);
        b_resp_cfg = 2'b00;
        $display("store with SLVERR: err=%b rdata=%h", er, rd);
        total++; if (to || er !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL bresp_err: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
        r_resp_cfg = 2'b11; r_force = 1'b1; r_force_data = 32'hCAFE_F00D;
        do_req(1'b0, 16'h0008, 32'h0, 4'h0, rd, er, lat, ra, to);
        r_resp_cfg = 2'b00; r_force = 1'b0;
        $display("load with DECERR: err=%b rdata=%h", er, rd);
        total++; if (to || er !== 1'b1 || rd !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL rresp_err: got err=%b rdata=%h want err=1 rdata=cafef00d", er, rd); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL rsp_hold: got v=%b err=%b rdata=%h want 0/1/cafef00d", rsp_valid, rsp_err, rsp_rdata); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er, ra, to; int lat; int r0; int n;
        for (int k = 0; k < 2; k++) begin
            r0 = rsp_log_n;
            req_we = (k == 0); req_addr = (k == 0) ? 16'h0030 : 16'h0010;
            req_wdata = 32'h7777_7777; req_wstrb = 4'hF; req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (k == 1) begin
                n = 0;
                while (!m_axil_rready && n < 20) begin @(posedge clk); #1; n++; end
            end
            total++;
            if ((k == 0 && m_axil_awvalid !== 1'b1) || (k == 1 && m_axil_rready !== 1'b1)) begin
                bad++; $display("FAIL reset_mid%0d_setup: got awv=%b rr=%b, want transaction in flight", k, m_axil_awvalid, m_axil_rready);
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            $display("reset during %s: awv=%b wv=%b arv=%b br=%b rr=%b ready=%b", (k == 0) ? "WR_ADDR_DATA" : "RD_DATA",
                     m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready, req_ready);
            total++;
            if ({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready, rsp_valid} !== 6'b0
                || req_ready !== 1'b1) begin
                bad++; $display("FAIL reset_mid%0d_outputs: got valids/readies=%b req_ready=%b want 0/1", k,
                                {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready, rsp_valid}, req_ready);
            end
            repeat (4) @(posedge clk);
            #1;
            total++; if (rsp_log_n !== r0) begin bad++; $display("FAIL reset_mid%0d_no_rsp: got %0d responses want 0", k, rsp_log_n - r0); end
        end
        do_req(1'b0, 16'h0010, 32'h0, 4'h0, rd, er, lat, ra, to);
        $display("load 0x0010 after reset: rdata=%h err=%b", rd, er);
        total++; if (to || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            bad++; $display("FAIL reset_recover_load: got %h err=%b want deadbeef err=0", rd, er); end
    endtask

    task automatic test_back_to_back;
        int acc [8];
        int base, n, got;
        base = rsp_log_n;
        req_we = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 16'h0020 + 16'(4 * i);
            n = 0;
            while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            acc[i] = cyc;
        end
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        got = rsp_log_n - base;
        total++; if (got !== 8) begin bad++; $display("FAIL b2b_count: got %0d responses want 8", got); end
        for (int i = 0; i < 8 && i < got; i++) begin
            $display("b2b load %0d: accept=%0d rsp=%0d data=%h", i, acc[i], rsp_cyc_log[base+i], rsp_dat_log[base+i]);
            if (i > 0) begin
                total++;
                if (acc[i] - acc[i-1] !== 4) begin bad++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, acc[i] - acc[i-1]); end
            end
            total++;
            if (rsp_cyc_log[base+i] - acc[i] !== 3) begin
                bad++; $display("FAIL b2b_latency%0d: got %0d edges want 3", i, rsp_cyc_log[base+i] - acc[i]); end
            total++;
            if (rsp_dat_log[base+i] !== 32'hA000_0000 + i) begin
                bad++; $display("FAIL b2b_data%0d: got %h want %h", i, rsp_dat_log[base+i], 32'hA000_0000 + i); end
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_partial_store;
        test_stalls;
        test_errors;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
